// File: rtl/cp0_exc_sched.sv
// Exception/interrupt scheduler between the pipeline and CP0.
// Picks one event in IDLE, drains the pipeline, issues a single-cycle cop_op,
// redirects fetch, then resumes. Also hosts the COUNT/COMPARE timer.
module cp0_exc_sched #(
  parameter logic [31:0] EXC_ENTRY = 32'h80000180,
  parameter int unsigned DRAIN_MAX = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        syscall_req,
  input  logic        break_req,
  input  logic        eret_req,
  input  logic [31:0] req_pc,
  input  logic [5:0]  hard_int,
  input  logic [31:0] status,
  input  logic [1:0]  sw_int,
  input  logic        cmp_wr,
  input  logic [31:0] cmp_val,
  input  logic [31:0] cop_rdata,
  input  logic        drain_ack,
  output logic        stall_req,
  output logic [3:0]  cop_op,
  output logic [31:0] next_pc_o,
  output logic        redirect,
  output logic [31:0] redirect_pc,
  output logic        exc_ack,
  output logic        irq_taken,
  output logic [31:0] count
);

  localparam logic [3:0] COP_OP_NOP = 4'd0;
  localparam logic [3:0] COP_OP_SYS = 4'd1;
  localparam logic [3:0] COP_OP_BRK = 4'd2;
  localparam logic [3:0] COP_OP_RET = 4'd3;

  localparam logic [2:0] StIdle   = 3'd0;
  localparam logic [2:0] StDrain  = 3'd1;
  localparam logic [2:0] StEnter  = 3'd2;
  localparam logic [2:0] StRet    = 3'd3;
  localparam logic [2:0] StResume = 3'd4;

  localparam logic [1:0] KindSys  = 2'd0;
  localparam logic [1:0] KindBrk  = 2'd1;
  localparam logic [1:0] KindEret = 2'd2;
  localparam logic [1:0] KindInt  = 2'd3;

  localparam int unsigned CntW = $clog2(DRAIN_MAX + 1);
  localparam logic [CntW-1:0] CntLast = CntW'(DRAIN_MAX - 1);

  logic [2:0]      state_q, state_d;
  logic [1:0]      kind_q, kind_d;
  logic [31:0]     pc_q, pc_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [31:0]     count_q, compare_q, count_inc;
  logic            tip_q;
  logic [7:0]      int_vec;
  logic            int_pend;
  logic            unused_status;

  assign unused_status = ^{status[31:16], status[7:3]};

  // Timer interrupt shares line 7 with hard_int[5].
  assign int_vec  = {tip_q | hard_int[5], hard_int[4:0], sw_int};
  assign int_pend = (|(int_vec & status[15:8])) & status[0] & ~status[1] & ~status[2];

  assign count_inc = count_q + 32'd1;
  assign count     = count_q;

  // COUNT/COMPARE timer; a COMPARE write clears tip even if the match hits that cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q   <= 32'd0;
      compare_q <= 32'hFFFF_FFFF;
      tip_q     <= 1'b0;
    end else begin
      count_q <= count_inc;
      if (cmp_wr) begin
        compare_q <= cmp_val;
        tip_q     <= 1'b0;
      end else if (count_inc == compare_q) begin
        tip_q <= 1'b1;
      end
    end
  end

  // Next-state: latch winner and pc in IDLE, count drain cycles.
  always_comb begin
    state_d = state_q;
    kind_d  = kind_q;
    pc_d    = pc_q;
    cnt_d   = cnt_q;
    case (state_q)
      StIdle: begin
        if (syscall_req || break_req || eret_req || int_pend) begin
          state_d = StDrain;
          cnt_d   = '0;
          pc_d    = req_pc;
          if (syscall_req)    kind_d = KindSys;
          else if (break_req) kind_d = KindBrk;
          else if (eret_req)  kind_d = KindEret;
          else                kind_d = KindInt;
        end
      end
      StDrain: begin
        if (drain_ack || (cnt_q == CntLast)) begin
          state_d = (kind_q == KindEret) ? StRet : StEnter;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StEnter, StRet: state_d = StResume;
      default:        state_d = StIdle;
    endcase
  end

  // State registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      kind_q  <= KindSys;
      pc_q    <= 32'd0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      kind_q  <= kind_d;
      pc_q    <= pc_d;
      cnt_q   <= cnt_d;
    end
  end

  // Outputs decoded from state; all idle values coincide with reset values.
  always_comb begin
    stall_req   = 1'b0;
    cop_op      = COP_OP_NOP;
    redirect    = 1'b0;
    redirect_pc = 32'd0;
    exc_ack     = 1'b0;
    irq_taken   = 1'b0;
    next_pc_o   = pc_q;
    case (state_q)
      StDrain: stall_req = 1'b1;
      StEnter: begin
        stall_req   = 1'b1;
        cop_op      = (kind_q == KindSys) ? COP_OP_SYS : COP_OP_BRK;
        redirect    = 1'b1;
        redirect_pc = EXC_ENTRY;
        exc_ack     = (kind_q != KindInt);
        irq_taken   = (kind_q == KindInt);
      end
      StRet: begin
        stall_req   = 1'b1;
        cop_op      = COP_OP_RET;
        redirect    = 1'b1;
        redirect_pc = cop_rdata;
        exc_ack     = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_cp0_exc_sched.sv
// Bench for cp0_exc_sched: timeline-based reference model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_cp0_exc_sched;

  localparam logic [31:0] ENTRY = 32'h80000180;
  localparam int DMAX = 16;
  localparam logic [3:0] OP_NOP = 4'd0;
  localparam logic [3:0] OP_SYS = 4'd1;
  localparam logic [3:0] OP_BRK = 4'd2;
  localparam logic [3:0] OP_RET = 4'd3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        syscall_req = 0, break_req = 0, eret_req = 0;
  logic [31:0] req_pc = 0;
  logic [5:0]  hard_int = 0;
  logic [31:0] status = 0;
  logic [1:0]  sw_int = 0;
  logic        cmp_wr = 0;
  logic [31:0] cmp_val = 0;
  logic [31:0] cop_rdata = 0;
  logic        drain_ack = 0;
  logic        stall_req;
  logic [3:0]  cop_op;
  logic [31:0] next_pc_o;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        exc_ack;
  logic        irq_taken;
  logic [31:0] count;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  cp0_exc_sched #(.EXC_ENTRY(ENTRY), .DRAIN_MAX(DMAX)) dut (
    .clk(clk), .rst(rst), .syscall_req(syscall_req), .break_req(break_req),
    .eret_req(eret_req), .req_pc(req_pc), .hard_int(hard_int), .status(status),
    .sw_int(sw_int), .cmp_wr(cmp_wr), .cmp_val(cmp_val), .cop_rdata(cop_rdata),
    .drain_ack(drain_ack), .stall_req(stall_req), .cop_op(cop_op), .next_pc_o(next_pc_o),
    .redirect(redirect), .redirect_pc(redirect_pc), .exc_ack(exc_ack),
    .irq_taken(irq_taken), .count(count)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Each accepted event is described by its accept cycle (first drain cycle) and
  // its action cycle; outputs in any cycle follow from where that cycle falls.
  int unsigned m_count;
  logic [31:0] m_cmp;
  bit          m_tip, m_busy, m_pend;
  int          k, acc, act, m_kind;  // kind: 0 syscall, 1 break, 2 eret, 3 irq
  logic [31:0] m_pc;
  logic [7:0]  m_src;
  logic [7:0]  e_ctl;
  logic [31:0] e_rpc;

  initial begin
    forever begin
      @(posedge clk);
      if (rst) begin
        m_count = 0; m_cmp = 32'hFFFF_FFFF; m_tip = 0; m_busy = 0;
        k = 0; acc = 0; act = -1; m_kind = 0; m_pc = 0;
      end else begin
        m_src  = {(m_tip | hard_int[5]), hard_int[4:0], sw_int};
        m_pend = ((m_src & status[15:8]) != 8'd0) && status[0] && !status[1] && !status[2];
        k++;
        if (m_busy && act >= 0 && k == act + 2) begin
          m_busy = 0;
        end else if (!m_busy) begin
          if (syscall_req || break_req || eret_req || m_pend) begin
            m_busy = 1; acc = k; act = -1; m_pc = req_pc;
            m_kind = syscall_req ? 0 : break_req ? 1 : eret_req ? 2 : 3;
          end
        end else if (act < 0 && (drain_ack || (k - acc) == DMAX)) begin
          act = k;
        end
        m_count = m_count + 1;
        if (cmp_wr) begin
          m_cmp = cmp_val; m_tip = 0;
        end else if (m_count == m_cmp) begin
          m_tip = 1;
        end
      end
      #1;
      if (!rst) begin
        // ctl = {stall, cop_op, redirect, exc_ack, irq_taken}
        e_ctl = 8'h00; e_rpc = 32'd0;
        if (m_busy && act < 0) e_ctl = 8'h80;
        else if (m_busy && k == act) begin
          case (m_kind)
            0: e_ctl = {1'b1, OP_SYS, 3'b110};
            1: e_ctl = {1'b1, OP_BRK, 3'b110};
            2: e_ctl = {1'b1, OP_RET, 3'b110};
            default: e_ctl = {1'b1, OP_BRK, 3'b101};
          endcase
          e_rpc = (m_kind == 2) ? cop_rdata : ENTRY;
          if (m_kind != 2) check("model next_pc_o", next_pc_o, m_pc);
        end
        check("model ctl", {24'd0, stall_req, cop_op, redirect, exc_ack, irq_taken},
              {24'd0, e_ctl});
        check("model redirect_pc", redirect_pc, e_rpc);
        check("model count", count, m_count);
      end
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic wait_redirect(input string name);
    bit seen;
    seen = 0;
    for (int i = 0; i < 60 && !seen; i++) begin
      @(negedge clk);
      if (redirect) seen = 1;
    end
    check({name, " redirect seen"}, {31'd0, seen}, 32'd1);
  endtask

  int unsigned c0;
  int          n;
  bit          seen_stall;

  initial begin
    #1;
    check("reset stall_req", {31'd0, stall_req}, 32'd0);
    check("reset cop_op", {28'd0, cop_op}, {28'd0, OP_NOP});
    check("reset count", count, 32'd0);
    check("reset redirect_pc", redirect_pc, 32'd0);
    check("reset next_pc_o", next_pc_o, 32'd0);
    repeat (2) @(negedge clk);
    rst = 0;
    repeat (3) @(negedge clk);

    // Syscall, drain_ack after 3 cycles; a break pulse during drain is ignored.
    syscall_req = 1; req_pc = 32'h0040_0010;
    @(negedge clk); break_req = 1;
    @(negedge clk); break_req = 0;
    @(negedge clk); drain_ack = 1;
    wait_redirect("syscall");
    check("syscall cop_op", {28'd0, cop_op}, {28'd0, OP_SYS});
    check("syscall next_pc_o", next_pc_o, 32'h0040_0010);
    check("syscall redirect_pc", redirect_pc, 32'h8000_0180);
    check("syscall exc_ack", {31'd0, exc_ack}, 32'd1);
    syscall_req = 0; drain_ack = 0;
    repeat (4) @(negedge clk);

    // Reset in the middle of DRAIN.
    syscall_req = 1; req_pc = 32'h0040_0050;
    repeat (2) @(negedge clk);
    check("mid-drain stall", {31'd0, stall_req}, 32'd1);
    #2 rst = 1;
    #1;
    check("async rst stall", {31'd0, stall_req}, 32'd0);
    check("async rst count", count, 32'd0);
    check("async rst ctl", {28'd0, cop_op}, {28'd0, OP_NOP});
    check("async rst redirect", {31'd0, redirect}, 32'd0);
    syscall_req = 0;
    @(negedge clk);
    rst = 0;
    @(negedge clk);
    check("post rst idle", {31'd0, stall_req}, 32'd0);
    check("post rst count", count, 32'd1);
    repeat (2) @(negedge clk);

    // Syscall + break + hard_int[2] together: SYS first, then BRK.
    status = 32'h0000_FF01; hard_int = 6'h04; drain_ack = 1;
    syscall_req = 1; break_req = 1; req_pc = 32'h0040_0100;
    wait_redirect("prio1");
    check("prio1 cop_op", {28'd0, cop_op}, {28'd0, OP_SYS});
    check("prio1 irq_taken", {31'd0, irq_taken}, 32'd0);
    syscall_req = 0; status = 32'h0000_FF03;  // handler entry sets EXL
    wait_redirect("prio2");
    check("prio2 cop_op", {28'd0, cop_op}, {28'd0, OP_BRK});
    check("prio2 exc_ack", {31'd0, exc_ack}, 32'd1);
    break_req = 0; hard_int = 0;
    repeat (4) @(negedge clk);
    status = 32'd0;
    @(negedge clk);

    // Timer interrupt via COMPARE write.
    status = 32'h0000_8001; req_pc = 32'h0040_0300;
    c0 = count; cmp_wr = 1; cmp_val = count + 32'd5;
    @(negedge clk); cmp_wr = 0;
    wait_redirect("timer");
    check("timer cop_op", {28'd0, cop_op}, {28'd0, OP_BRK});
    check("timer irq_taken", {31'd0, irq_taken}, 32'd1);
    check("timer exc_ack", {31'd0, exc_ack}, 32'd0);
    check("timer latency count", count, c0 + 32'd7);
    status = 32'h0000_8003;
    @(negedge clk);
    cmp_wr = 1; cmp_val = count + 32'd5000;
    @(negedge clk); cmp_wr = 0;
    repeat (2) @(negedge clk);
    status = 32'd0;

    // ERET returns to cop_rdata.
    eret_req = 1; cop_rdata = 32'h0040_0020;
    wait_redirect("eret");
    check("eret cop_op", {28'd0, cop_op}, {28'd0, OP_RET});
    check("eret redirect_pc", redirect_pc, 32'h0040_0020);
    check("eret exc_ack", {31'd0, exc_ack}, 32'd1);
    eret_req = 0;
    repeat (3) @(negedge clk);

    // No drain_ack: ENTER forced after DRAIN_MAX cycles; EXL masks pending IRQs.
    drain_ack = 0; status = 32'h0000_FF03; hard_int = 6'h3F;
    syscall_req = 1; req_pc = 32'h0040_0200;
    seen_stall = 0;
    for (int i = 0; i < 10 && !seen_stall; i++) begin
      @(negedge clk);
      if (stall_req) seen_stall = 1;
    end
    check("forced stall seen", {31'd0, seen_stall}, 32'd1);
    syscall_req = 0;  // dropped during drain, must still complete
    n = 0;
    for (int i = 0; i < 40 && !redirect; i++) begin
      @(negedge clk);
      n++;
    end
    check("forced drain length", n, DMAX);
    check("forced cop_op", {28'd0, cop_op}, {28'd0, OP_SYS});
    check("forced next_pc_o", next_pc_o, 32'h0040_0200);
    repeat (20) @(negedge clk);
    check("EXL masks irq", {31'd0, stall_req}, 32'd0);
    hard_int = 0; status = 32'd0;
    repeat (3) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
